// File: rtl/tom_regbus_pkg.sv
// Shared definitions for the Tom register-bus initiator: FSM encoding,
// error data default and register offsets within the F00000 window.
package tom_regbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    localparam logic [15:0] ERR_DATA_DEFAULT = 16'hFFFF;

    // Byte offsets of commonly used Tom registers
    localparam logic [15:0] REG_HC    = 16'h0004;
    localparam logic [15:0] REG_VC    = 16'h0006;
    localparam logic [15:0] REG_OLP   = 16'h0020;
    localparam logic [15:0] REG_OBF   = 16'h0026;
    localparam logic [15:0] REG_VMODE = 16'h0028;
    localparam logic [15:0] REG_PIT0  = 16'h0050;
    localparam logic [15:0] REG_PIT1  = 16'h0052;
    localparam logic [15:0] REG_INT1  = 16'h00E0;
    localparam logic [15:0] REG_INT2  = 16'h00E2;

    function automatic logic is_misaligned(input logic [15:0] addr);
        return addr[0];
    endfunction

endpackage

// File: rtl/tom_regbus_timer.sv
// Loadable down-counter that saturates at zero; done flags the terminal count.
module tom_regbus_timer #(
    parameter int WIDTH = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/tom_regbus_master.sv
// Single-beat initiator for the Tom register bus: address setup, read/write
// strobes, ack wait with timeout, and a one-cycle completion response.
module tom_regbus_master
    import tom_regbus_pkg::*;
#(
    parameter int          STROBE_CYC = 2,
    parameter int          TIMEOUT    = 64,
    parameter logic [15:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_we,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] a,
    output logic        intdev,
    output logic        reads,
    output logic        oet,
    output logic        intwe,
    output logic        intswe,
    output logic        wet,
    output logic [15:0] dwr,
    input  logic [15:0] drd,
    input  logic        ourack
);

    state_t      state_reg;
    logic        we_reg;
    logic        ack_seen_reg;
    logic [15:0] rdata_cap_reg;
    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic [15:0] rsp_rdata_reg;
    logic        rsp_err_reg;
    logic [15:0] a_reg;
    logic        intdev_reg;
    logic        reads_reg;
    logic        oet_reg;
    logic        intwe_reg;
    logic        intswe_reg;
    logic        wet_reg;
    logic [15:0] dwr_reg;

    logic        strobe_done;
    logic        timeout_done;
    logic        in_bus;
    logic        ack_now;
    logic        acked;
    logic        done_ok;
    logic        done_err;
    logic        go_wait;
    logic        finish;
    logic        accept;
    logic [15:0] rsp_data_next;

    assign in_bus = (state_reg == ST_ACTIVE) || (state_reg == ST_WAIT);

    // Both timers are loaded on the SETUP->ACTIVE edge; the timeout keeps
    // running through WAIT while the strobe timer only spans ACTIVE.
    tom_regbus_timer #(.WIDTH(4)) u_strobe_timer (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (state_reg == ST_SETUP),
        .en       (state_reg == ST_ACTIVE),
        .load_val (4'(STROBE_CYC - 1)),
        .done     (strobe_done)
    );

    tom_regbus_timer #(.WIDTH(10)) u_timeout_timer (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (state_reg == ST_SETUP),
        .en       (in_bus),
        .load_val (10'(TIMEOUT - 1)),
        .done     (timeout_done)
    );

    always_comb begin
        ack_now  = in_bus && ourack;
        acked    = ack_seen_reg || ack_now;
        done_ok  = 1'b0;
        done_err = 1'b0;
        go_wait  = 1'b0;
        case (state_reg)
            ST_ACTIVE: begin
                if (strobe_done) begin
                    if (acked)             done_ok  = 1'b1;
                    else if (timeout_done) done_err = 1'b1;
                    else                   go_wait  = 1'b1;
                end else if (!acked && timeout_done) begin
                    done_err = 1'b1;
                end
            end
            ST_WAIT: begin
                if (ourack)            done_ok  = 1'b1;
                else if (timeout_done) done_err = 1'b1;
            end
            default: ;
        endcase
        finish = done_ok || done_err;
        accept = (state_reg == ST_IDLE) && req_ready_reg && req_valid;

        // An ack arriving on the finishing edge has not been latched yet
        if (done_err)          rsp_data_next = ERR_DATA;
        else if (we_reg)       rsp_data_next = 16'h0000;
        else if (ack_seen_reg) rsp_data_next = rdata_cap_reg;
        else                   rsp_data_next = drd;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg     <= ST_IDLE;
            we_reg        <= 1'b0;
            ack_seen_reg  <= 1'b0;
            rdata_cap_reg <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            a_reg         <= '0;
            intdev_reg    <= 1'b0;
            reads_reg     <= 1'b0;
            oet_reg       <= 1'b0;
            intwe_reg     <= 1'b0;
            intswe_reg    <= 1'b0;
            wet_reg       <= 1'b0;
            dwr_reg       <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready_reg <= 1'b0;
                        we_reg        <= req_we;
                        ack_seen_reg  <= 1'b0;
                        if (is_misaligned(req_addr)) begin
                            state_reg     <= ST_RECOVER;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_rdata_reg <= ERR_DATA;
                        end else begin
                            state_reg  <= ST_SETUP;
                            a_reg      <= req_addr;
                            intdev_reg <= 1'b1;
                            dwr_reg    <= req_we ? req_wdata : 16'h0000;
                        end
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_reg  <= ST_ACTIVE;
                    reads_reg  <= !we_reg;
                    oet_reg    <= !we_reg;
                    intwe_reg  <= we_reg;
                    wet_reg    <= we_reg;
                    intswe_reg <= we_reg;
                end
                ST_ACTIVE, ST_WAIT: begin
                    intswe_reg <= 1'b0;
                    if (ack_now && !ack_seen_reg) begin
                        ack_seen_reg  <= 1'b1;
                        rdata_cap_reg <= drd;
                    end
                    if (finish) begin
                        state_reg     <= ST_RECOVER;
                        a_reg         <= '0;
                        intdev_reg    <= 1'b0;
                        reads_reg     <= 1'b0;
                        oet_reg       <= 1'b0;
                        intwe_reg     <= 1'b0;
                        wet_reg       <= 1'b0;
                        dwr_reg       <= '0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= done_err;
                        rsp_rdata_reg <= rsp_data_next;
                    end else if (go_wait) begin
                        state_reg <= ST_WAIT;
                        oet_reg   <= 1'b0;
                        wet_reg   <= 1'b0;
                    end
                end
                ST_RECOVER: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            assert (!(reads_reg && intwe_reg));
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign a         = a_reg;
    assign intdev    = intdev_reg;
    assign reads     = reads_reg;
    assign oet       = oet_reg;
    assign intwe     = intwe_reg;
    assign intswe    = intswe_reg;
    assign wet       = wet_reg;
    assign dwr       = dwr_reg;

endmodule

// File: tb/tb_tom_regbus_master.sv
// Randomized bench for tom_regbus_master: a transaction-level timeline model
// predicts every output each cycle, plus literal checks on directed cases.
module tb_tom_regbus_master;
    import tom_regbus_pkg::*;

    localparam int          S   = 2;
    localparam int          TO  = 64;
    localparam logic [15:0] ERR = 16'hFFFF;

    typedef struct packed {
        logic        req_ready;
        logic        rsp_valid;
        logic [15:0] rsp_rdata;
        logic        rsp_err;
        logic [15:0] a;
        logic        intdev;
        logic        reads;
        logic        oet;
        logic        intwe;
        logic        intswe;
        logic        wet;
        logic [15:0] dwr;
    } obs_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_we;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] a;
    logic        intdev;
    logic        reads;
    logic        oet;
    logic        intwe;
    logic        intswe;
    logic        wet;
    logic [15:0] dwr;
    logic [15:0] drd;
    logic        ourack;

    int   checks = 0;
    int   failures = 0;
    int   txn_id = 0;
    int   txn_cyc = 0;
    bit   check_en = 0;
    obs_t exp_o;
    obs_t act_o;

    int          rsp_cyc;
    logic [15:0] rsp_rd;
    logic        rsp_e;
    int          intswe_cnt;
    int          wet_cnt;
    int          oet_cnt;
    int          busact_cnt;

    always #5 sys_clk = ~sys_clk;

    tom_regbus_master #(
        .STROBE_CYC (S),
        .TIMEOUT    (TO),
        .ERR_DATA   (ERR)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .a         (a),
        .intdev    (intdev),
        .reads     (reads),
        .oet       (oet),
        .intwe     (intwe),
        .intswe    (intswe),
        .wet       (wet),
        .dwr       (dwr),
        .drd       (drd),
        .ourack    (ourack)
    );

    // Compare process: every cycle, full output vector vs the model
    always @(negedge sys_clk) begin
        if (check_en) begin
            act_o.req_ready = req_ready;
            act_o.rsp_valid = rsp_valid;
            act_o.rsp_rdata = rsp_rdata;
            act_o.rsp_err   = rsp_err;
            act_o.a         = a;
            act_o.intdev    = intdev;
            act_o.reads     = reads;
            act_o.oet       = oet;
            act_o.intwe     = intwe;
            act_o.intswe    = intswe;
            act_o.wet       = wet;
            act_o.dwr       = dwr;
            checks++;
            if (act_o !== exp_o) begin
                failures++;
                $display("FAIL outputs txn=%0d cyc=%0d got=%h want=%h", txn_id, txn_cyc, act_o, exp_o);
            end
            checks++;
            if (reads === 1'b1 && intwe === 1'b1) begin
                failures++;
                $display("FAIL overlap txn=%0d cyc=%0d reads=%b intwe=%b want not both", txn_id, txn_cyc, reads, intwe);
            end
            if (rsp_valid === 1'b1) begin
                rsp_cyc = txn_cyc;
                rsp_rd  = rsp_rdata;
                rsp_e   = rsp_err;
            end
            if (intswe === 1'b1) intswe_cnt++;
            if (wet === 1'b1)    wet_cnt++;
            if (oet === 1'b1)    oet_cnt++;
            if (intdev === 1'b1 || reads === 1'b1 || intwe === 1'b1) busact_cnt++;
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic idle(input int n, input logic ready);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            req_addr  = 16'($urandom);
            ourack    = 1'($urandom);
            drd       = 16'($urandom);
            exp_o = '0;
            exp_o.req_ready = ready;
            step();
        end
    endtask

    // k: ACTIVE cycle index (0 = first) of the single ack pulse, -1 = never.
    // abort_at: transaction cycle in which sys_rst is asserted, -1 = none.
    task automatic run_txn(input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                           input int k, input logic [15:0] drd_ack, input int abort_at);
        int          rec;
        logic        err;
        logic        mis;
        logic [15:0] ack_data;
        mis = addr[0];
        ack_data = 16'h0000;
        if (mis) begin
            rec = 1; err = 1'b1;
        end else if (k >= 0 && k < TO) begin
            rec = 2 + ((k + 1 > S) ? k + 1 : S); err = 1'b0;
        end else begin
            rec = 2 + TO; err = 1'b1;
        end
        txn_id++;
        txn_cyc    = 0;
        rsp_cyc    = -1;
        rsp_rd     = 16'h0000;
        rsp_e      = 1'b0;
        intswe_cnt = 0;
        wet_cnt    = 0;
        oet_cnt    = 0;
        busact_cnt = 0;

        req_valid = 1'b1;
        req_addr  = addr;
        req_we    = we;
        req_wdata = wdata;
        ourack    = 1'($urandom);
        drd       = 16'($urandom);
        exp_o = '0;
        exp_o.req_ready = 1'b1;
        step();

        for (int c = 1; c <= rec; c++) begin
            txn_cyc   = c;
            req_valid = 1'($urandom);
            req_addr  = 16'($urandom);
            req_we    = 1'($urandom);
            req_wdata = 16'($urandom);
            drd       = 16'($urandom);
            if (!mis && c >= 2 && c < rec) begin
                ourack = (c == 2 + k);
                if (c == 2 + k) begin
                    drd      = drd_ack;
                    ack_data = drd_ack;
                end
            end else begin
                ourack = 1'($urandom);
            end
            exp_o = '0;
            if (c < rec) begin
                exp_o.a      = addr;
                exp_o.intdev = 1'b1;
                exp_o.dwr    = we ? wdata : 16'h0000;
                if (c >= 2) begin
                    exp_o.reads  = !we;
                    exp_o.intwe  = we;
                    exp_o.oet    = !we && (c < 2 + S);
                    exp_o.wet    = we && (c < 2 + S);
                    exp_o.intswe = we && (c == 2);
                end
            end else begin
                exp_o.rsp_valid = 1'b1;
                exp_o.rsp_err   = err;
                exp_o.rsp_rdata = err ? ERR : (we ? 16'h0000 : ack_data);
            end
            if (c == abort_at) begin
                sys_rst = 1'b1;
                step();
                sys_rst   = 1'b0;
                req_valid = 1'b0;
                ourack    = 1'b0;
                txn_cyc   = c + 1;
                exp_o     = '0;
                step();
                return;
            end
            step();
        end
    endtask

    initial begin
        logic [15:0] r_addr;
        int          r_k;
        sys_rst   = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_wdata = '0;
        drd       = '0;
        ourack    = 1'b0;
        exp_o     = '0;
        step();
        step();
        check_en = 1;
        step();
        sys_rst = 1'b0;
        step();

        // Read HC, ack in first ACTIVE cycle
        run_txn(REG_HC, 1'b0, 16'h0000, 0, 16'h0123, -1);
        check_lit("hc_rsp_cycle", rsp_cyc, 4);
        check_lit("hc_rdata", int'(rsp_rd), 16'h0123);
        check_lit("hc_err", int'(rsp_e), 0);
        check_lit("hc_oet_cycles", oet_cnt, 2);
        idle(1, 1'b1);

        // Write INT1, ack five cycles after ACTIVE entry
        run_txn(REG_INT1, 1'b1, 16'h0101, 5, 16'h9999, -1);
        check_lit("int1_rsp_cycle", rsp_cyc, 8);
        check_lit("int1_rdata", int'(rsp_rd), 0);
        check_lit("int1_err", int'(rsp_e), 0);
        check_lit("int1_intswe_pulses", intswe_cnt, 1);
        check_lit("int1_wet_cycles", wet_cnt, 2);

        // Read with no ack: timeout
        run_txn(REG_HC, 1'b0, 16'h0000, -1, 16'h0000, -1);
        check_lit("timeout_rsp_cycle", rsp_cyc, 66);
        check_lit("timeout_rdata", int'(rsp_rd), 16'hFFFF);
        check_lit("timeout_err", int'(rsp_e), 1);

        // Misaligned request
        run_txn(16'h0003, 1'b0, 16'h0000, 0, 16'h0000, -1);
        check_lit("misalign_rsp_cycle", rsp_cyc, 1);
        check_lit("misalign_bus_activity", busact_cnt, 0);
        check_lit("misalign_err", int'(rsp_e), 1);

        // Reset in WAIT of a write, then a normal read
        run_txn(REG_INT1, 1'b1, 16'h5A5A, -1, 16'h0000, 2 + S + 1);
        check_lit("abort_no_rsp", rsp_cyc, -1);
        run_txn(REG_VC, 1'b0, 16'h0000, 0, 16'hBEEF, -1);
        check_lit("post_reset_rsp_cycle", rsp_cyc, 4);
        check_lit("post_reset_rdata", int'(rsp_rd), 16'hBEEF);

        // Back-to-back: second accepted right after RECOVER
        run_txn(REG_PIT0, 1'b1, 16'h1234, 0, 16'h0000, -1);
        run_txn(REG_OLP, 1'b0, 16'h0000, 1, 16'h7777, -1);
        check_lit("b2b_rsp_cycle", rsp_cyc, 4);
        check_lit("b2b_rdata", int'(rsp_rd), 16'h7777);

        for (int i = 0; i < 40; i++) begin
            r_addr = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 7) != 0) r_addr[0] = 1'b0;
            r_k = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 8));
            run_txn(r_addr, 1'($urandom), 16'($urandom), r_k, 16'($urandom), -1);
            idle(int'($urandom_range(0, 2)), 1'b1);
        end

        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tom_regbus_master.md
Name: tom_regbus_master

Overview:
- Host-side initiator for the Tom internal register bus.
- Turns a single-beat request (address, write flag, 16-bit data) into a bus cycle: drives a[15:0] and intdev, then the read-path strobes (reads/oet) or write-path strobes (intwe/intswe/wet).
- Waits for ourack from the register decode side, then returns read data or write completion.
- Used by the debug/host bridge and by the bench to reach video-timing, object-processor and interrupt registers in the F00000-F000FF window.

Parameters:
- STROBE_CYC, 2, cycles wet/oet stay high in ACTIVE (1..15).
- TIMEOUT, 64, cycles waited for ourack before the cycle is aborted (2..1023).
- ERR_DATA, 16'hFFFF, rsp_rdata value returned on timeout or misaligned access.

Ports:
- sys_clk  in  1  single system clock; all logic rises on it.
- sys_rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (IDLE only).
- req_addr  in  16  byte address within the register window.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  read data, or ERR_DATA on error; 0 for a successful write.
- rsp_err  out  1  qualifies rsp_valid: timeout or misaligned.
- a  out  16  bus address.
- intdev  out  1  internal-device select.
- reads  out  1  read cycle in progress.
- oet  out  1  output-enable timing strobe.
- intwe  out  1  internal write cycle in progress.
- intswe  out  1  internal short-write enable; pulses in the first ACTIVE cycle of a write.
- wet  out  1  write-enable timing strobe.
- dwr  out  16  write data driven to the register bus.
- drd  in  16  read data from the register bus.
- ourack  in  1  register-side acknowledge.

Behaviour:
- Reset values: all outputs 0 (a=0, dwr=0, rsp_rdata=0); state IDLE; counters 0.
- Reset mid-cycle drops every strobe in the same edge. No response is issued for the aborted request.
- FSM: IDLE -> SETUP -> ACTIVE -> WAIT -> RECOVER -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr/we/wdata.
  - If req_addr[0]=1 (misaligned): go straight to RECOVER with err, no bus activity. rsp_valid is issued 1 cycle after acceptance.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - a=addr and intdev=1. These hold through WAIT and clear in RECOVER.
  - On writes, dwr=wdata, held through WAIT.
- ACTIVE (STROBE_CYC cycles):
  - Read: reads=1 and oet=1.
  - Write: intwe=1 and wet=1; intswe=1 in the first ACTIVE cycle only.
  - wet/oet drop on leaving ACTIVE. reads/intwe hold until RECOVER.
- ourack may arrive in ACTIVE or WAIT.
  - Sampled high in ACTIVE: the ack is latched, ACTIVE still runs its full STROBE_CYC, then WAIT is skipped.
  - WAIT exits on the first cycle ourack=1.
- Read data: drd is captured on the edge ourack is sampled high.
- Timeout:
  - A counter starts at entry to ACTIVE.
  - If ourack has not been seen when the count reaches TIMEOUT, go to RECOVER with err=1.
  - The counter saturates and does not wrap.
- RECOVER (1 cycle): all bus outputs 0; rsp_valid=1.
  - Read success: rsp_rdata=captured data.
  - Write success: rsp_rdata=0.
  - Error: rsp_rdata=ERR_DATA, rsp_err=1.
- Latency with ack in the first ACTIVE cycle: req accept to rsp_valid = 2+STROBE_CYC cycles. Back-to-back requests are accepted the cycle after RECOVER.
- req_valid is ignored outside IDLE. Inputs are not re-sampled while a cycle is in flight.
- ourack outside ACTIVE/WAIT is ignored.
- reads and intwe are never high together; assert this in simulation.

Decomposition:
- Shared package tom_regbus_pkg holds:
  - the state encoding (5 states, 3 bits);
  - ERR_DATA default;
  - register address constants (HC, VC, OLP, INT1, PIT0, ...) for the bench and host bridge.
- One natural sub-module: tom_regbus_timer, the shared STROBE/TIMEOUT down-counter with load, enable and a terminal flag.
- The FSM and datapath stay in the top block.

Test Plan:
- Read 0x0004 (HC), drd=16'h0123, ourack high on the 1st ACTIVE cycle, STROBE_CYC=2 -> a=0x0004 from SETUP, reads/oet high 2 cycles, rsp_valid at cycle 4, rsp_rdata=0x0123, rsp_err=0.
- Write 0x00E0 (INT1) data 0x0101, ourack after 5 cycles -> intswe a single pulse, wet high 2 cycles, dwr=0x0101 through WAIT, rsp_valid with rsp_rdata=0, no err.
- Read with ourack never asserted, TIMEOUT=64 -> rsp_err=1, rsp_rdata=0xFFFF 64 cycles after ACTIVE entry; bus outputs 0 in RECOVER.
- Request addr 0x0003 -> no intdev/reads/intwe activity, rsp_valid 1 cycle after accept, rsp_err=1.
- sys_rst pulsed during WAIT of a write -> all strobes 0 on the next edge, no rsp_valid; a new read is then accepted and completes normally.
- Two back-to-back requests with req_valid held high -> second accepted exactly 1 cycle after the first rsp_valid; reads/intwe never overlap.
